// File: rtl/rr_case_arbiter_pkg.sv
// Shared types and helpers for the round-robin case arbiter.
// FSM encoding, width helper and the rotating-index wrap.
package rr_case_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/rr_case_arbiter_pick.sv
// Rotating-priority encoder: first set req bit at or after ptr,
// searching upward and wrapping from N-1 to 0.
module rr_pick
  import rr_case_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] sel,
  output logic           any
);

  logic [IDW-1:0] idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'(wrap(int'(ptr) + i, N));
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/rr_case_arbiter.sv
// Round-robin arbiter with release handshake and hold timeout.
// Grant, index and timeout are all registered.
module rr_case_arbiter
  import rr_case_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   rel,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int CW = clog2(MAX_HOLD);
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST = IDW'(N - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           to_q, to_d;

  logic [IDW-1:0] sel;
  logic           any;
  logic           own_end;
  logic           hold_end;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (sel),
    .any (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
    end
  end

  // Owner handshake wins over the hold limit on the same edge.
  assign own_end  = rel[id_q] || !req[id_q];
  assign hold_end = (cnt_q == LIM);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    to_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          id_d       = sel;
          cnt_d      = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (own_end || hold_end) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
          to_d    = !own_end;
          ptr_d   = (id_q == LAST) ? '0 : id_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_id    = id_q;
    gnt_valid = (state_q == ST_GRANT);
    timeout   = to_q;
  end

endmodule

// File: doc/rr_case_arbiter.md
Name: rr_case_arbiter

Overview:
- Round-robin arbiter that shares one case-decoded output driver among N requesters.
- Registers a one-hot grant and a binary grant index. Downstream decode logic uses the index as its case selector, with a default assignment for the idle value.
- Sequences ownership with a request/release handshake and a hold-timeout, so no requester can starve the others.

Parameters:
- N, 4, number of requesters (2..16)
- IDW, 2, width of grant index; must satisfy 2**IDW >= N
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release (>= 2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  N  per-requester request level
- release  input  N  per-requester release strobe; only the current owner's bit is honoured
- gnt  output  N  one-hot grant, registered
- gnt_id  output  IDW  binary index of owner, registered; case selector for downstream decode
- gnt_valid  output  1  high while any grant is held
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset values (immediate while reset high; mid-grant reset drops the grant the same instant):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0
  - priority pointer ptr=0, hold counter cnt=0, state=IDLE
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first asserted req at or after ptr, searching upward and wrapping from N-1 to 0.
  - Next edge: gnt=onehot(sel), gnt_id=sel, gnt_valid=1, cnt=0, state=GRANT.
  - Grant latency is 1 cycle from req sampled in IDLE.
  - If req == 0, outputs stay 0 and the state stays IDLE.
- GRANT: end conditions are evaluated each edge in this priority order:
  1. release[gnt_id]=1, or req[gnt_id]=0: normal end, timeout stays 0.
  2. cnt == MAX_HOLD-1: forced end, timeout=1 for exactly one cycle, coinciding with gnt dropping.
  3. Otherwise cnt increments and the grant holds.
- On any end:
  - gnt=0, gnt_valid=0, state=IDLE.
  - ptr = gnt_id+1, wrapping to 0 at N.
  - gnt_id keeps its last value (gnt_valid qualifies it).
- The IDLE cycle after a grant is a mandatory one-cycle bubble. Back-to-back owners are separated by exactly one cycle with gnt=0.
- release bits of non-owners are ignored in all states. release in IDLE is ignored.
- Simultaneous release and cnt limit on the same edge: treat as a normal end, timeout=0.
- A requester whose req drops between sampling and grant is not a concern, because requests are sampled at grant time only.
- gnt always has at most one bit set; gnt == (gnt_valid ? 1<<gnt_id : 0) at every edge.
- Width rules:
  - cnt is ceil(log2(MAX_HOLD)) bits and never wraps.
  - ptr is IDW bits; values >= N are never produced.

Decomposition:
- Package rr_case_arbiter_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - a function for width (clog2) used for cnt
- Sub-module rr_pick: purely combinational rotating-priority encoder.
  - Inputs: req, ptr. Outputs: sel index, any.
  - Implemented as a default-assigned output followed by a case/loop override, so no latch is inferred.
- The top level holds the FSM, counter and output registers.

Test Plan:
1. Reset, then req=4'b0000 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
2. req=4'b0101 from ptr=0 -> next edge gnt=4'b0001, gnt_id=0. Pulse release[0] -> gnt=0 for one cycle, then gnt=4'b0100, gnt_id=2, ptr afterwards=3.
3. req[3] held high with no release, MAX_HOLD=8 -> gnt=4'b1000 for exactly 8 cycles. timeout=1 on the cycle gnt drops. ptr wraps to 0.
4. Owner 1 held; release=4'b0100 (non-owner) -> ignored, gnt stays 4'b0010. Then req[1] drops -> grant ends with timeout=0.
5. Assert reset asynchronously mid-grant (between edges) -> gnt, gnt_valid and gnt_id go to 0 immediately. After reset drops with req=4'b1111 -> first grant is index 0.
6. All four requesters held continuously with release pulsed each grant -> grant order 0,1,2,3,0, one bubble cycle between each, with no repeats before wrap.
